ysyx_23060025_icache_sa: RTL and testbench
==========================================

Name: ysyx_23060025_icache_sa

Overview:
Parametrised N-way set-associative instruction cache between the IFU fetch port and the AXI4 read-only DRAM path. It is the successor to the direct-mapped icache and adds the following:
- per-line valid bits
- configurable associativity with per-set round-robin replacement
- a FENCE.I-style invalidate
- AXI read-error reporting
Hits return in 2 cycles. Misses refill a whole line with one INCR burst.

Parameters:
- ADDR_WIDTH, 32, physical address width
- DATA_WIDTH, 32, IFU/AXI data width; only 32 is supported
- WAYS, 2, associativity; power of two, 1..8
- SET_ADDR_W, 4, log2(number of sets)
- LINE_OFF_ADDR_W, 4, log2(line bytes); line holds 2**(LINE_OFF_ADDR_W-2) words, minimum 2 words

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- in_paddr  in  32  fetch address, word-aligned, stable while in_psel=1 and until in_pready
- in_psel  in  1  fetch request, held until in_pready
- in_flush  in  1  one-cycle invalidate-all pulse
- in_pready  out  1  one-cycle response strobe
- in_prdata  out  32  instruction word, valid while in_pready=1
- in_pslverr  out  1  refill error; valid while in_pready=1
- out_araddr  out  32  line-aligned burst address
- out_arvalid  out  1  AR valid
- out_arready  in  1  AR ready
- out_arlen  out  8  beats-1 = WORDS-1
- out_arsize  out  3  3'b010 (4 bytes)
- out_arburst  out  2  2'b01 (INCR)
- out_rvalid  in  1  R valid
- out_rready  out  1  R ready
- out_rdata  in  32  R data
- out_rresp  in  2  R response; nonzero = error
- out_rlast  in  1  last beat

Behaviour:
- Address split: tag = [31:SET_ADDR_W+LINE_OFF_ADDR_W], set = next SET_ADDR_W bits, word = [LINE_OFF_ADDR_W-1:2].
- Storage per set/way: data line, tag, valid. Per set: victim pointer of log2(WAYS) bits.
- Reset (reset=0 at a clock edge):
  - state goes to IDLE; all valid bits and victim pointers clear to 0
  - all outputs go to 0, except arsize, arburst and arlen, which may hold constants
  - an in-flight burst is abandoned; the interconnect is reset alongside
  - data and tag arrays need no reset.
- FSM states: IDLE, CHECK, AR, R, FILL, RESP.
- IDLE: if in_psel, go to CHECK.
- CHECK: compare all ways in parallel. Hit = valid && tag match.
  - Hit: go to RESP; in_prdata is taken from the hit way and word; in_pslverr=0.
  - Miss: go to AR; the victim is the lowest-numbered invalid way in the set, otherwise the way named by the victim pointer.
- AR:
  - out_arvalid=1, out_araddr = {tag, set, 0}; these stay stable until out_arready.
  - Handshake done: arvalid drops next cycle and the FSM goes to R.
- R:
  - out_rready=1; each beat writes victim word[beat_cnt]; beat_cnt runs 0..WORDS-1.
  - Any nonzero rresp sets a sticky err flag.
  - rvalid && rlast moves to FILL. The cache does not check that beat count equals arlen+1; the beat with rlast terminates the refill.
- FILL:
  - err=0: write tag, set valid, advance the victim pointer by 1 mod WAYS.
  - err=1: leave valid=0 and do not advance the pointer.
  - Either way, go to RESP.
- RESP:
  - in_pready=1 for exactly one cycle; in_prdata = requested word, in_pslverr = err.
  - Clear err; go to IDLE.
- Latency: request seen in IDLE at cycle t. Hit: in_pready at t+2. Miss: in_pready 2 cycles after the rlast beat.
- Flush:
  - In IDLE, in_flush clears all valid bits at that edge.
  - In any other state, the flush is latched as pending and applied on the edge entering IDLE. The in-flight fetch still completes with the refilled data.
  - Flush together with psel in IDLE: invalidate, then CHECK misses.
  - Two flushes while busy collapse into one.
- in_psel is ignored outside IDLE. A request that is dropped before in_pready is a protocol violation; behaviour is undefined.
- WAYS=1 degenerates to direct-mapped with no victim pointer.

Optional Feature:
Macro YSYX_23060025_ICACHE_PERF_EN.
- Defined:
  - adds output ports perf_hit_cnt[31:0] and perf_miss_cnt[31:0]
  - hit counter increments on each CHECK->RESP; miss counter increments on each CHECK->AR
  - both wrap at 2^32 and clear on reset
  - adds DPI calls cache_hit_statistic/cache_cycle_statistic, guarded additionally by N_YOSYS_STA_CHECK
- Undefined: the ports and counters are absent; functionality is identical.

Decomposition:
- ysyx_23060025_define.v holds the shared constants: AXI_ADDR_SIZE_4, AXI_ADDR_BURST_INCR, the AXI RESP_OKAY value, and the icache state encodings (`ICACHE_S_*).
- One natural sub-module: ysyx_23060025_icache_way. It holds the data/tag/valid arrays for one way and provides:
  - combinational hit and read word out
  - refill-word write, tag write and flush inputs
- Top module: instantiates WAYS copies of the way; contains the FSM, victim select, beat counter and AXI/IFU outputs.

Test Plan:
- Cold miss: reset, fetch 0x3000_0004 with WAYS=2, LINE_OFF_ADDR_W=4 -> araddr=0x3000_0000, arlen=3, arsize=2, arburst=1; beats D0..D3 -> in_prdata=D1, pready 2 cycles after rlast.
- Hit: refetch 0x3000_0008 -> no AR; pready at t+2; prdata=D2.
- Replacement: fetch 0x3000_0000, 0x3000_0200, 0x3000_0400 (same set 0) -> third miss evicts way0; refetch 0x3000_0200 hits, 0x3000_0000 misses.
- Flush during refill: in_flush mid-R for 0x3000_0000 -> correct word returned; the next fetch of the same address misses again.
- Error: rresp=2'b10 on beat 1 -> pready with pslverr=1; refetch misses; the following fetch returns pslverr=0.
- Reset mid-burst: drive reset=0 in R -> pready=0, arvalid=0, rready=0 next cycle; after release, a fetch misses.

Source files
------------

// File: rtl/ysyx_23060025_icache_sa_pkg.sv
// Shared constants for the set-associative instruction cache.
//   - ICACHE_S_* : FSM state encodings (legacy-compatible constants)
//   - AXI_ADDR_SIZE_4, AXI_ADDR_BURST_INCR, AXI_RESP_OKAY : AXI4 field values
//   - victim_width() : pointer width helper (at least one bit)
package ysyx_23060025_icache_sa_pkg;

  localparam logic [2:0] ICACHE_S_IDLE  = 3'd0;
  localparam logic [2:0] ICACHE_S_CHECK = 3'd1;
  localparam logic [2:0] ICACHE_S_AR    = 3'd2;
  localparam logic [2:0] ICACHE_S_R     = 3'd3;
  localparam logic [2:0] ICACHE_S_FILL  = 3'd4;
  localparam logic [2:0] ICACHE_S_RESP  = 3'd5;

  localparam logic [2:0] AXI_ADDR_SIZE_4     = 3'b010;
  localparam logic [1:0] AXI_ADDR_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;

  function automatic int unsigned victim_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060025_icache_sa_way.sv
// One way of the instruction cache: data lines, tags and valid bits.
// Ports:
//   clock, reset      : clock, synchronous active-low reset (clears valid only)
//   set_idx, tag      : lookup set and tag (also the write set/tag)
//   word_idx          : word selected for rdata
//   hit, line_valid   : tag match with valid line / valid bit of the set
//   rdata             : combinational read word
//   wr_word_en/idx/data : refill word write
//   tag_wr_en         : write tag and mark line valid
//   inv_en            : mark the line of set_idx invalid
//   flush             : clear all valid bits
module ysyx_23060025_icache_way
  import ysyx_23060025_icache_sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_W      = 24,
  parameter int unsigned SET_ADDR_W = 4,
  parameter int unsigned WORD_W     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SET_ADDR_W-1:0] set_idx,
  input  logic [TAG_W-1:0]      tag,
  input  logic [WORD_W-1:0]     word_idx,
  output logic                  hit,
  output logic                  line_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wr_word_en,
  input  logic [WORD_W-1:0]     wr_word_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tag_wr_en,
  input  logic                  inv_en,
  input  logic                  flush
);

  localparam int unsigned SETS  = 1 << SET_ADDR_W;
  localparam int unsigned WORDS = 1 << WORD_W;

  logic [DATA_WIDTH-1:0] data_q [SETS][WORDS];
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [SETS-1:0]       valid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (tag_wr_en) begin
      valid_q[set_idx] <= 1'b1;
    end else if (inv_en) begin
      valid_q[set_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_word_en) data_q[set_idx][wr_word_idx] <= wr_data;
    if (tag_wr_en)  tag_q[set_idx] <= tag;
  end

  assign line_valid = valid_q[set_idx];
  assign hit        = valid_q[set_idx] && (tag_q[set_idx] == tag);
  assign rdata      = data_q[set_idx][word_idx];

endmodule

// File: rtl/ysyx_23060025_icache_sa.sv
// N-way set-associative instruction cache between the IFU fetch port and an
// AXI4 read-only path. Hits answer two cycles after the request; misses
// refill a whole line with one INCR burst.
// Ports:
//   clock, reset                  : clock, synchronous active-low reset
//   in_paddr/in_psel/in_flush     : fetch request and invalidate-all pulse
//   in_pready/in_prdata/in_pslverr: one-cycle response with word and error
//   out_ar*                       : AXI read address channel
//   out_r*                        : AXI read data channel
// Optional (macro YSYX_23060025_ICACHE_PERF_EN):
//   perf_hit_cnt, perf_miss_cnt   : wrapping hit/miss counters
module ysyx_23060025_icache_sa
  import ysyx_23060025_icache_sa_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WAYS            = 2,
  parameter int unsigned SET_ADDR_W      = 4,
  parameter int unsigned LINE_OFF_ADDR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_paddr,
  input  logic                  in_psel,
  input  logic                  in_flush,
  output logic                  in_pready,
  output logic [DATA_WIDTH-1:0] in_prdata,
  output logic                  in_pslverr,
  output logic [ADDR_WIDTH-1:0] out_araddr,
  output logic                  out_arvalid,
  input  logic                  out_arready,
  output logic [7:0]            out_arlen,
  output logic [2:0]            out_arsize,
  output logic [1:0]            out_arburst,
  input  logic                  out_rvalid,
  output logic                  out_rready,
  input  logic [DATA_WIDTH-1:0] out_rdata,
  input  logic [1:0]            out_rresp,
  input  logic                  out_rlast
`ifdef YSYX_23060025_ICACHE_PERF_EN
  ,
  output logic [31:0]           perf_hit_cnt,
  output logic [31:0]           perf_miss_cnt
`endif
);

  localparam int unsigned TAG_W = ADDR_WIDTH - SET_ADDR_W - LINE_OFF_ADDR_W;
  localparam int unsigned WORD_W = LINE_OFF_ADDR_W - 2;
  localparam int unsigned WORDS = 1 << WORD_W;
  localparam int unsigned SETS = 1 << SET_ADDR_W;
  localparam int unsigned VW = victim_width(WAYS);

  logic [2:0]            state_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [VW-1:0]         victim_q;
  logic [VW-1:0]         victim_c;
  logic [VW-1:0]         ptr_cur;
  logic [WORD_W-1:0]     beat_q;
  logic                  err_q;
  logic                  flush_pend_q;
  logic [DATA_WIDTH-1:0] resp_q;

  logic [TAG_W-1:0]      tag_f;
  logic [SET_ADDR_W-1:0] set_f;
  logic [WORD_W-1:0]     word_f;
  logic                  unused_addr_bits;

  logic [WAYS-1:0]       way_hit;
  logic [WAYS-1:0]       way_valid;
  logic [DATA_WIDTH-1:0] way_rdata [WAYS];
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  any_hit;
  logic                  flush_now;

  assign tag_f            = in_paddr[ADDR_WIDTH-1 -: TAG_W];
  assign set_f            = in_paddr[LINE_OFF_ADDR_W +: SET_ADDR_W];
  assign word_f           = in_paddr[2 +: WORD_W];
  assign unused_addr_bits = ^in_paddr[1:0];

  // A flush seen while busy is deferred to the edge that returns to IDLE, so
  // the in-flight refill still completes and answers with its own data.
  assign flush_now = ((state_q == ICACHE_S_IDLE) && in_flush) ||
                     ((state_q == ICACHE_S_RESP) && (flush_pend_q || in_flush));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ysyx_23060025_icache_way #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_W      (TAG_W),
      .SET_ADDR_W (SET_ADDR_W),
      .WORD_W     (WORD_W)
    ) u_way (
      .clock       (clock),
      .reset       (reset),
      .set_idx     (set_f),
      .tag         (tag_f),
      .word_idx    (word_f),
      .hit         (way_hit[w]),
      .line_valid  (way_valid[w]),
      .rdata       (way_rdata[w]),
      .wr_word_en  ((state_q == ICACHE_S_R) && out_rvalid && (victim_q == VW'(w))),
      .wr_word_idx (beat_q),
      .wr_data     (out_rdata),
      .tag_wr_en   ((state_q == ICACHE_S_FILL) && !err_q && (victim_q == VW'(w))),
      .inv_en      ((state_q == ICACHE_S_CHECK) && !any_hit && (victim_c == VW'(w))),
      .flush       (flush_now)
    );
  end

  assign any_hit = |way_hit;

  always_comb begin
    hit_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_data = hit_data | way_rdata[w];
    end
  end

  // Prefer the lowest-numbered invalid way; otherwise follow the pointer.
  always_comb begin
    logic found;
    found    = 1'b0;
    victim_c = ptr_cur;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !way_valid[w]) begin
        victim_c = VW'(w);
        found    = 1'b1;
      end
    end
  end

  if (WAYS > 1) begin : g_ptr
    logic [VW-1:0] ptr_q [SETS];
    always_ff @(posedge clock) begin
      if (!reset) begin
        for (int unsigned s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if ((state_q == ICACHE_S_FILL) && !err_q) begin
        ptr_q[set_f] <= ptr_q[set_f] + VW'(1);
      end
    end
    assign ptr_cur = ptr_q[set_f];
  end else begin : g_no_ptr
    assign ptr_cur = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ICACHE_S_IDLE;
      araddr_q     <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      if (in_flush && (state_q != ICACHE_S_IDLE)) flush_pend_q <= 1'b1;
      case (state_q)
        ICACHE_S_IDLE: begin
          if (in_psel) state_q <= ICACHE_S_CHECK;
        end
        ICACHE_S_CHECK: begin
          if (any_hit) begin
            resp_q  <= hit_data;
            state_q <= ICACHE_S_RESP;
          end else begin
            araddr_q <= {in_paddr[ADDR_WIDTH-1:LINE_OFF_ADDR_W], {LINE_OFF_ADDR_W{1'b0}}};
            victim_q <= victim_c;
            beat_q   <= '0;
            state_q  <= ICACHE_S_AR;
          end
        end
        ICACHE_S_AR: begin
          if (out_arready) state_q <= ICACHE_S_R;
        end
        ICACHE_S_R: begin
          if (out_rvalid) begin
            if (out_rresp != AXI_RESP_OKAY) err_q <= 1'b1;
            // Capture the requested word as it streams past.
            if (beat_q == word_f) resp_q <= out_rdata;
            beat_q <= beat_q + WORD_W'(1);
            if (out_rlast) state_q <= ICACHE_S_FILL;
          end
        end
        ICACHE_S_FILL: begin
          state_q <= ICACHE_S_RESP;
        end
        ICACHE_S_RESP: begin
          err_q        <= 1'b0;
          flush_pend_q <= 1'b0;
          state_q      <= ICACHE_S_IDLE;
        end
        default: begin
          state_q <= ICACHE_S_IDLE;
        end
      endcase
    end
  end

  assign in_pready   = (state_q == ICACHE_S_RESP);
  assign in_prdata   = (state_q == ICACHE_S_RESP) ? resp_q : '0;
  assign in_pslverr  = (state_q == ICACHE_S_RESP) && err_q;
  assign out_araddr  = araddr_q;
  assign out_arvalid = (state_q == ICACHE_S_AR);
  assign out_rready  = (state_q == ICACHE_S_R);
  assign out_arlen   = 8'(WORDS - 1);
  assign out_arsize  = AXI_ADDR_SIZE_4;
  assign out_arburst = AXI_ADDR_BURST_INCR;

`ifdef YSYX_23060025_ICACHE_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (state_q == ICACHE_S_CHECK) begin
      if (any_hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else         perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060025_icache_sa.sv
module tb_ysyx_23060025_icache_sa;

  localparam int WORDS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_flush = 1'b0;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic [31:0] out_araddr;
  logic        out_arvalid;
  logic        out_arready = 1'b0;
  logic [7:0]  out_arlen;
  logic [2:0]  out_arsize;
  logic [1:0]  out_arburst;
  logic        out_rvalid = 1'b0;
  logic        out_rready;
  logic [31:0] out_rdata = '0;
  logic [1:0]  out_rresp = '0;
  logic        out_rlast = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        miss;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  ysyx_23060025_icache_sa #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .WAYS            (2),
    .SET_ADDR_W      (4),
    .LINE_OFF_ADDR_W (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_paddr    (in_paddr),
    .in_psel     (in_psel),
    .in_flush    (in_flush),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .in_pslverr  (in_pslverr),
    .out_araddr  (out_araddr),
    .out_arvalid (out_arvalid),
    .out_arready (out_arready),
    .out_arlen   (out_arlen),
    .out_arsize  (out_arsize),
    .out_arburst (out_arburst),
    .out_rvalid  (out_rvalid),
    .out_rready  (out_rready),
    .out_rdata   (out_rdata),
    .out_rresp   (out_rresp),
    .out_rlast   (out_rlast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // err_beat: beat index answered with SLVERR (-1 none)
  // flush_beat: beat index carrying in_flush (-1 none, -2 together with psel)
  task automatic fetch(input logic [31:0] a, input logic exp_miss,
                       input int err_beat, input int flush_beat);
    exp_t        e;
    logic [31:0] line;
    logic [31:0] ar_first;
    int          beat;
    int          last_i;
    int          ar_cnt;
    int          ar_wait;
    bit          gapped;
    bit          done;
    e.data = mem_word(a);
    e.err  = (err_beat >= 0);
    e.miss = exp_miss;
    sb_q.push_back(e);
    line     = a & 32'hFFFF_FFF0;
    ar_first = '0;
    beat = 0; last_i = -100; ar_cnt = 0; ar_wait = 0; gapped = 0; done = 0;
    @(negedge clock);
    in_paddr = a;
    in_psel  = 1'b1;
    in_flush = (flush_beat == -2);
    for (int i = 1; i <= 300 && !done; i++) begin
      @(negedge clock);
      out_arready = 1'b0;
      out_rvalid  = 1'b0;
      out_rlast   = 1'b0;
      out_rresp   = 2'b00;
      in_flush    = 1'b0;
      if (out_arvalid) begin
        if (ar_wait == 0) begin
          ar_first = out_araddr;
          ar_cnt++;
          check("araddr", out_araddr, line);
          check("arlen", 32'(out_arlen), 32'd3);
          check("arsize", 32'(out_arsize), 32'd2);
          check("arburst", 32'(out_arburst), 32'd1);
        end else begin
          check("araddr_stable", out_araddr, ar_first);
        end
        ar_wait++;
        if (ar_wait == 2) out_arready = 1'b1;
      end
      if (out_rready && beat < WORDS) begin
        if (beat == 2 && !gapped) begin
          gapped = 1;
        end else begin
          out_rvalid = 1'b1;
          out_rdata  = mem_word(line + 32'(beat * 4));
          out_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
          out_rlast  = (beat == WORDS - 1);
          if (beat == flush_beat) in_flush = 1'b1;
          if (beat == WORDS - 1) last_i = i;
          beat++;
        end
      end
      if (in_pready) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("pslverr", 32'(in_pslverr), 32'(e.err));
          if (!e.err) check("prdata", in_prdata, e.data);
          check("ar_count", 32'(ar_cnt), 32'(e.miss));
          check("latency", 32'(i), e.miss ? 32'(last_i + 2) : 32'd2);
        end
        in_psel = 1'b0;
        done    = 1;
      end
    end
    if (!done) begin
      check("timeout", 32'd0, 32'd1);
      in_psel = 1'b0;
      void'(sb_q.pop_back());
    end
  endtask

  task automatic reset_mid_burst(input logic [31:0] a);
    bit seen;
    seen = 0;
    @(negedge clock);
    in_paddr = a;
    in_psel  = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      out_arready = out_arvalid;
      if (out_rready) seen = 1;
    end
    check("reach_r", 32'(seen), 32'd1);
    out_arready = 1'b0;
    out_rvalid  = 1'b1;
    out_rdata   = mem_word(a & 32'hFFFF_FFF0);
    reset       = 1'b0;
    in_psel     = 1'b0;
    @(negedge clock);
    out_rvalid = 1'b0;
    check("rst_pready", 32'(in_pready), 32'd0);
    check("rst_arvalid", 32'(out_arvalid), 32'd0);
    check("rst_rready", 32'(out_rready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_pready", 32'(in_pready), 32'd0);
    check("reset_prdata", in_prdata, 32'd0);
    check("reset_pslverr", 32'(in_pslverr), 32'd0);
    check("reset_arvalid", 32'(out_arvalid), 32'd0);
    check("reset_rready", 32'(out_rready), 32'd0);
    check("reset_araddr", out_araddr, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Cold miss, then hits in the same line.
    fetch(32'h3000_0004, 1'b1, -1, -1);
    fetch(32'h3000_0008, 1'b0, -1, -1);
    fetch(32'h3000_0000, 1'b0, -1, -1);

    // Three lines in set 0 with two ways: round-robin replacement.
    fetch(32'h3000_0200, 1'b1, -1, -1);
    fetch(32'h3000_0400, 1'b1, -1, -1);
    fetch(32'h3000_0204, 1'b0, -1, -1);
    fetch(32'h3000_0000, 1'b1, -1, -1);
    fetch(32'h3000_040C, 1'b0, -1, -1);

    // Flush during refill: word still returned, everything invalid afterwards.
    fetch(32'h3000_0010, 1'b1, -1, 1);
    fetch(32'h3000_0014, 1'b1, -1, -1);
    fetch(32'h3000_0400, 1'b1, -1, -1);
    fetch(32'h3000_0018, 1'b0, -1, -1);

    // Read error on beat 1: error reported, line stays invalid.
    fetch(32'h3000_0020, 1'b1, 1, -1);
    fetch(32'h3000_0020, 1'b1, -1, -1);
    fetch(32'h3000_0024, 1'b0, -1, -1);

    // Flush together with a request in IDLE: invalidate, then miss.
    fetch(32'h3000_0024, 1'b1, -1, -2);
    fetch(32'h3000_002C, 1'b0, -1, -1);

    // Reset in the middle of a burst, then everything misses again.
    reset_mid_burst(32'h3000_0040);
    fetch(32'h3000_0040, 1'b1, -1, -1);
    fetch(32'h3000_0024, 1'b1, -1, -1);
    fetch(32'h3000_0044, 1'b0, -1, -1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
